// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the PC, keeps one variable-latency imem transaction in flight,
// and buffers responses in an out entry plus a skid entry so stalls never lose a word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallf,
  input  logic        pcsrce,
  input  logic [31:0] pctargete,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrf,
  output logic [31:0] pcf,
  output logic [31:0] pcplus4f,
  output logic        fvalid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_fvalid;
  logic [31:0] r_instr;
  logic [31:0] r_pcf;
  logic [31:0] r_pcp4;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic        w_out_free;
  logic        w_accept;
  logic        w_skid_next;
  logic [31:0] w_target;

  // Out entry is free when empty or consumed this edge; a response spills to skid otherwise.
  always_comb begin
    w_target    = pctargete & ~32'd3;
    w_out_free  = ~r_fvalid | ~stallf;
    w_accept    = (r_state == S_REQ) & imem_rvalid & ~pcsrce;
    w_skid_next = (w_accept & r_skid_valid) | (~w_out_free & (r_skid_valid | w_accept));
  end

  // Request FSM, PC and the out/skid buffer; redirect overrides stall and response handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_fvalid     <= 1'b0;
      r_instr      <= NOP;
      r_pcf        <= RESET_PC;
      r_pcp4       <= RESET_PC + 32'd4;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP;
      r_skid_pc    <= RESET_PC;
    end else if (pcsrce) begin
      r_pc         <= w_target;
      r_fvalid     <= 1'b0;
      r_instr      <= NOP;
      r_skid_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_addr  <= w_target;
        end
        S_REQ, S_KILL: begin
          // A transaction still in flight must drain before the target can be issued.
          r_req <= 1'b1;
          if (imem_rvalid) begin
            r_state <= S_REQ;
            r_addr  <= w_target;
          end else begin
            r_state <= S_KILL;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_fvalid <= 1'b1;
          r_instr  <= r_skid_instr;
          r_pcf    <= r_skid_pc;
          r_pcp4   <= r_skid_pc + 32'd4;
        end else if (w_accept) begin
          r_fvalid <= 1'b1;
          r_instr  <= imem_rdata;
          r_pcf    <= r_pc;
          r_pcp4   <= r_pc + 32'd4;
        end else begin
          r_fvalid <= 1'b0;
          r_instr  <= NOP;
        end
      end
      if (w_accept && w_skid_next) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_pc;
      end else if (w_out_free) begin
        r_skid_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_skid_next) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_REQ: begin
          if (imem_rvalid) begin
            if (w_skid_next) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end else begin
              r_addr <= r_pc + 32'd4;
            end
          end
        end
        S_KILL: begin
          if (imem_rvalid) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instrf    = r_instr;
  assign pcf       = r_pcf;
  assign pcplus4f  = r_pcp4;
  assign fvalid    = r_fvalid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, expected-PC-stream scoreboard,
// directed scenarios followed by a randomized stall/redirect/reset phase.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallf;
  logic        pcsrce;
  logic [31:0] pctargete;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrf;
  logic [31:0] pcf;
  logic [31:0] pcplus4f;
  logic        fvalid;

  int n_checks = 0;
  int n_errors = 0;
  int n_consumed = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stallf(stallf), .pcsrce(pcsrce), .pctargete(pctargete),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instrf(instrf), .pcf(pcf), .pcplus4f(pcplus4f), .fvalid(fvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers after mem_lat extra cycles of imem_req (0 = same cycle).
  int lat_mode = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  assign imem_rvalid = imem_req && (mem_cnt == mem_lat);
  assign imem_rdata  = memfn(imem_addr);

  function automatic int pick_lat();
    return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
  endfunction

  always @(posedge clk) begin
    if (reset || imem_rvalid) begin
      mem_cnt <= 0;
      mem_lat <= pick_lat();
    end else if (imem_req) begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // Reference: the delivered stream must be consecutive words from the last reset/redirect.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  task automatic restart_stream(input logic [31:0] base);
    exp_q.delete();
    exp_next = base;
  endtask

  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  logic        hold_vld = 1'b0;
  logic [31:0] held_pcf;
  logic [31:0] held_instr;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      restart_stream(32'h0000_0000);
      top_up();
      hold_vld = 1'b0;
      pend = 1'b0;
    end else begin
      chk("pcplus4f", pcplus4f, pcf + 32'd4);
      if (!fvalid) chk("nop_when_invalid", instrf, NOP);
      if (hold_vld) begin
        chk("stall_hold_valid", {31'd0, fvalid}, 32'd1);
        chk("stall_hold_pcf", pcf, held_pcf);
        chk("stall_hold_instr", instrf, held_instr);
      end
      if (pend) begin
        chk("req_held", {31'd0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, pend_addr);
      end
      if (pcsrce) begin
        restart_stream(pctargete & ~32'd3);
        top_up();
      end else if (fvalid && !stallf) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", pcf, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("stream_pcf", pcf, e);
          chk("stream_instr", instrf, memfn(e));
          n_consumed++;
          top_up();
        end
      end
      hold_vld   = fvalid && stallf && !pcsrce;
      held_pcf   = pcf;
      held_instr = instrf;
      pend       = imem_req && !imem_rvalid;
      pend_addr  = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_fvalid(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (fvalid) found = 1'b1;
      else tick();
    end
    chk({name, "_timeout"}, {31'd0, found}, 32'd1);
    if (found) chk({name, "_pcf"}, pcf, exp_pc);
  endtask

  initial begin
    int base_consumed;
    bit found;
    reset = 1'b1; stallf = 1'b0; pcsrce = 1'b0; pctargete = 32'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state, then 0-wait streaming
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fvalid", {31'd0, fvalid}, 32'd0);
    chk("rst_instr", instrf, NOP);
    chk("rst_pcf", pcf, 32'h0);
    chk("rst_pcp4", pcplus4f, 32'h4);
    chk("rst_addr", imem_addr, 32'h0);
    tick(); @(negedge clk);
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_fvalid", {31'd0, fvalid}, 32'd0);
    tick(); @(negedge clk);
    chk("c2_fvalid", {31'd0, fvalid}, 32'd1);
    chk("c2_pcf", pcf, 32'h0);
    chk("c2_instr", instrf, memfn(32'h0));
    tick(); @(negedge clk);
    chk("c3_pcf", pcf, 32'h4);

    // Three stalled cycles with pcf=8: skid fills, requests pause
    tick(); stallf = 1'b1; @(negedge clk);
    chk("c4_pcf", pcf, 32'h8);
    tick(); @(negedge clk);
    chk("c5_pcf", pcf, 32'h8);
    chk("c5_req", {31'd0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    chk("c6_req", {31'd0, imem_req}, 32'd0);
    tick(); stallf = 1'b0; @(negedge clk);
    chk("c7_pcf", pcf, 32'h8);
    tick(); @(negedge clk);
    chk("c8_pcf", pcf, 32'hC);
    chk("c8_addr", imem_addr, 32'h10);
    tick(); @(negedge clk);
    chk("c9_pcf", pcf, 32'h10);

    // Redirect while a 3-cycle fetch of 0x20 is outstanding
    lat_mode = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h20 && mem_cnt == 0) found = 1'b1;
    end
    chk("t3_reach_0x20", {31'd0, found}, 32'd1);
    pcsrce = 1'b1; pctargete = 32'h100;
    tick(); pcsrce = 1'b0;
    @(negedge clk);
    chk("t3_flush_fvalid", {31'd0, fvalid}, 32'd0);
    chk("t3_kill_addr", imem_addr, 32'h20);
    chk("t3_kill_req", {31'd0, imem_req}, 32'd1);
    tick();
    wait_fvalid("t3_first", 32'h100);

    // Redirect coinciding with a response: no drain cycle
    lat_mode = 0;
    do_reset();
    tick(); tick(); tick();
    pcsrce = 1'b1; pctargete = 32'h200;
    tick(); pcsrce = 1'b0;
    @(negedge clk);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_fvalid", {31'd0, fvalid}, 32'd0);
    tick(); @(negedge clk);
    chk("t4_pcf", pcf, 32'h200);

    // Unaligned redirect during stall
    stallf = 1'b1;
    tick(); tick();
    pcsrce = 1'b1; pctargete = 32'h103;
    tick(); pcsrce = 1'b0;
    @(negedge clk);
    chk("t5_fvalid0", {31'd0, fvalid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h100);
    tick(); @(negedge clk);
    chk("t5_fvalid1", {31'd0, fvalid}, 32'd1);
    chk("t5_pcf", pcf, 32'h100);
    chk("t5_pcp4", pcplus4f, 32'h104);
    tick(); stallf = 1'b0;

    // PC wrap at the top of the address space
    pcsrce = 1'b1; pctargete = 32'hFFFF_FFFC;
    tick(); pcsrce = 1'b0;
    tick(); @(negedge clk);
    chk("wrap_pcf", pcf, 32'hFFFF_FFFC);
    chk("wrap_pcp4", pcplus4f, 32'h0);
    tick(); @(negedge clk);
    chk("wrap_next_pcf", pcf, 32'h0);

    // Reset mid-transaction
    lat_mode = 2;
    repeat (8) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && mem_cnt == 1) found = 1'b1;
      else tick();
    end
    chk("t6_mid_txn", {31'd0, found}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_fvalid", {31'd0, fvalid}, 32'd0);
    chk("t6_pcf", pcf, 32'h0);
    tick();
    wait_fvalid("t6_refetch", 32'h0);

    // Randomized stall / redirect / reset traffic
    lat_mode = -1;
    base_consumed = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stallf = ($urandom_range(0, 9) < 3);
      pcsrce = ($urandom_range(0, 31) == 0);
      pctargete = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      reset = ($urandom_range(0, 399) == 0);
    end
    tick();
    stallf = 1'b0; pcsrce = 1'b0; reset = 1'b0;
    repeat (10) tick();
    chk("random_progress", {31'd0, (n_consumed - base_consumed) > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
